// File: rtl/processor_pc.sv
`default_nettype none
// ============================================================================
// Module   : processor_pc
// Purpose  : Program counter sequencer: increment, branch load, or halt-freeze.
// Revision : 1.0 - initial release
// ============================================================================
module processor_pc #(
    parameter int PC_W     = 10,
    parameter int RESET_PC = 0,
    parameter int PC_INC   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] BADR,
    input  logic            hlt,
    input  logic            bra,
    output logic [PC_W-1:0] PC,
    output logic            halted
);

    localparam logic [PC_W-1:0] C_RESET_PC = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] C_PC_INC   = PC_W'(PC_INC);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= C_RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Halt outranks branch; leaving HALT updates PC on the same edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (hlt) begin
            state_d = ST_HALT;
        end else begin
            state_d = ST_RUN;
            if (bra) begin
                pc_d = BADR;
            end else begin
                pc_d = pc_q + C_PC_INC;
            end
        end
    end

    assign PC     = pc_q;
    assign halted = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_processor_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_processor_pc
// Purpose  : Directed plus randomized checks of processor_pc against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_processor_pc;

    logic       clk;
    logic       rst;
    logic [9:0] BADR;
    logic       hlt;
    logic       bra;
    logic [9:0] PC;
    logic       halted;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    int m_pc     = 0;
    int m_halted = 0;

    processor_pc #(
        .PC_W    (10),
        .RESET_PC(0),
        .PC_INC  (1)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .BADR  (BADR),
        .hlt   (hlt),
        .bra   (bra),
        .PC    (PC),
        .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"}, {22'd0, PC}, m_pc);
        check({tag, ".halted"}, {31'd0, halted}, m_halted);
    endtask

    // Drive inputs, take one edge, advance the model, compare.
    task automatic step(input logic h, input logic b, input logic [9:0] a, input string tag);
        hlt  = h;
        bra  = b;
        BADR = a;
        @(posedge clk);
        #1;
        if (rst) begin
            if (h) begin
                m_halted = 1;
            end else begin
                m_halted = 0;
                m_pc     = b ? int'(a) : (m_pc + 1) % 1024;
            end
        end else begin
            m_pc     = 0;
            m_halted = 0;
        end
        check_state(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2;
        rst  = 1'b0;
        hlt  = 1'bx;
        bra  = 1'bx;
        BADR = 'x;
        #1;
        m_pc     = 0;
        m_halted = 0;
        check_state(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        hlt  = 1'b0;
        bra  = 1'b1;
        BADR = 10'd15;
        #1;
        check_state("reset_async");
        step(1'b0, 1'b1, 10'd15, "reset_hold1");
        step(1'b0, 1'b1, 10'd15, "reset_hold2");
        #2;
        rst = 1'b1;
        step(1'b0, 1'b1, 10'd15, "first_edge");

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 10'd0, "run");
        step(1'b0, 1'b1, 10'd15, "branch");
        step(1'b0, 1'b0, 10'd0, "after_branch1");
        step(1'b0, 1'b0, 10'd0, "after_branch2");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'd15, "halt_prio");
        step(1'b0, 1'b1, 10'd15, "resume_branch");
        step(1'b0, 1'b1, 10'd1022, "wrap_load");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, "wrap_run");
        step(1'b0, 1'b1, 10'd300, "load_300");
        step(1'b1, 1'b0, 10'd0, "halt_300");
        async_reset_pulse("reset_mid_halt");
        step(1'b0, 1'b0, 10'd0, "post_reset_run");
        step(1'b0, 1'b1, PC, "branch_self");

        for (int i = 0; i < 400; i++) begin
            logic       h, b;
            logic [9:0] a;
            h = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3))
                                            : 10'($urandom_range(0, 1023));
            step(h, b, a, "rand");
            if ($urandom_range(0, 39) == 0) async_reset_pulse("rand_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
